// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: refill FSM states,
// block geometry and the address-field width helpers.
package icache_pkg;

  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_ADDR_W    = 28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_READ,
    ST_UPDATE
  } state_t;

  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines);
    return BLOCK_ADDR_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Refill controller: IDLE -> MEM_READ -> UPDATE sequencer and the latched block
// address that drives the memory request for the whole refill.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        miss,
  input  logic [27:0] block_addr,
  input  logic        mem_busywait,
  output logic        busywait,
  output logic        mem_read,
  output logic        line_we,
  output logic [27:0] refill_addr
);

  state_t      state_reg;
  logic        mem_read_reg;
  logic [27:0] refill_addr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      mem_read_reg    <= 1'b0;
      refill_addr_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (miss) begin
            refill_addr_reg <= block_addr;
            mem_read_reg    <= 1'b1;
            state_reg       <= ST_MEM_READ;
          end
        end
        ST_MEM_READ: begin
          if (!mem_busywait) begin
            mem_read_reg <= 1'b0;
            state_reg    <= ST_UPDATE;
          end
        end
        ST_UPDATE: state_reg <= ST_IDLE;
        default: begin
          mem_read_reg <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

  // Reset overrides everything combinationally so the PC can load its reset value
  // and a data return coinciding with reset never writes a line.
  assign mem_read    = mem_read_reg & ~reset;
  assign line_we     = (state_reg == ST_MEM_READ) & ~mem_busywait & ~reset;
  assign busywait    = ~reset & ((state_reg == ST_IDLE) ? miss : 1'b1);
  assign refill_addr = refill_addr_reg;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with 16-byte blocks; zero-latency
// hits and a block refill from instruction memory on a miss.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  ADDRESS,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam int IDX        = index_width(LINES);
  localparam int TAG_W      = tag_width(LINES);
  localparam int BLOCK_BITS = BLOCK_BYTES * 8;

  logic [IDX-1:0]        index;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            offset;
  logic                  hit;
  logic                  line_we;
  logic [27:0]           refill_addr;
  logic [IDX-1:0]        fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic                  unused_addr_bits;

  logic [LINES-1:0]      valid_reg;
  logic [TAG_W-1:0]      tag_array  [LINES];
  logic [BLOCK_BITS-1:0] data_array [LINES];
  logic [31:0]           line_words [WORDS_PER_BLOCK];

  assign offset           = ADDRESS[3:2];
  assign index            = ADDRESS[4+IDX-1:4];
  assign tag              = ADDRESS[31:4+IDX];
  assign unused_addr_bits = ^ADDRESS[1:0];

  // The fill is steered only by the latched block address, never by ADDRESS.
  assign fill_index = refill_addr[IDX-1:0];
  assign fill_tag   = refill_addr[27:IDX];

  assign hit = valid_reg[index] && (tag_array[index] == tag);

  icache_ctrl u_ctrl (
    .clk          (CLK),
    .reset        (RESET),
    .miss         (~hit),
    .block_addr   (ADDRESS[31:4]),
    .mem_busywait (MEM_BUSYWAIT),
    .busywait     (BUSYWAIT),
    .mem_read     (MEM_READ),
    .line_we      (line_we),
    .refill_addr  (refill_addr)
  );

  assign MEM_ADDRESS = refill_addr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_reg <= '0;
    end else if (line_we) begin
      valid_reg[fill_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; validity alone gates their use.
  always_ff @(posedge CLK) begin
    if (line_we) begin
      tag_array[fill_index]  <= fill_tag;
      data_array[fill_index] <= MEM_READDATA;
    end
  end

  generate
    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
      assign line_words[gi] = data_array[index][32*gi +: 32];
    end
  endgenerate

  assign INSTRUCTION = (RESET || BUSYWAIT) ? 32'h0 : line_words[offset];

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: cold miss, hits, eviction, reset during
// refill, address change during refill and zero-wait memory.
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [31:0]  ADDRESS = 32'hFFFF_FFFC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int checks = 0;
  int errors = 0;
  int mem_k = 0;
  int mem_cnt = 0;

  instruction_cache #(.LINES(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory: busy for mem_k cycles after MEM_READ rises, then data valid.
  always @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT = (mem_cnt < mem_k);

  // Block 0 holds the reference pattern; others encode the block address per word.
  function automatic logic [127:0] blk_data(input logic [27:0] ba);
    if (ba == 28'h0) return 128'h33221100_77665544_BBAA9988_FFEEDDCC;
    return {ba[25:0], 4'hA, 2'd3, ba[25:0], 4'hA, 2'd2,
            ba[25:0], 4'hA, 2'd1, ba[25:0], 4'hA, 2'd0};
  endfunction
  assign MEM_READDATA = blk_data(MEM_ADDRESS);

  // Presents an address at a negedge and runs until BUSYWAIT is low (bounded).
  task automatic fetch(input logic [31:0] a, output int busy, output int rd,
                       output logic [27:0] ma);
    busy = 0; rd = 0; ma = 28'hFFFFFFF;
    @(negedge CLK);
    RESET = 1'b0;
    ADDRESS = a;
    #1;
    while (BUSYWAIT === 1'b1 && busy < 100) begin
      busy++;
      if (MEM_READ === 1'b1) begin
        rd++;
        ma = MEM_ADDRESS;
      end
      @(negedge CLK);
      #1;
    end
    checks++;
    if (busy >= 100) begin
      errors++;
      $display("FAIL fetch_timeout addr=%08h: busy %0d cycles, required < 100", a, busy);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      RESET = 1'b1;
      ADDRESS = 32'hFFFF_FFFC;
      #1;
      checks++;
      if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %b expected 0", BUSYWAIT); end
      checks++;
      if (MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", MEM_READ); end
      checks++;
      if (INSTRUCTION !== 32'h0) begin errors++; $display("FAIL reset_instr: got %08h expected 00000000", INSTRUCTION); end
      $display("reset cycle %0d: BUSYWAIT=%b MEM_READ=%b INSTRUCTION=%08h", i, BUSYWAIT, MEM_READ, INSTRUCTION);
    end
  endtask

  task automatic test_cold_miss();
    int busy, rd;
    logic [27:0] ma;
    mem_k = 4;
    fetch(32'h0, busy, rd, ma);
    $display("cold miss 0x0: busy=%0d rd=%0d mem_addr=%07h instr=%08h", busy, rd, ma, INSTRUCTION);
    checks++;
    if (busy != 7) begin errors++; $display("FAIL cold_busy_cycles: got %0d expected 7", busy); end
    checks++;
    if (rd != 5) begin errors++; $display("FAIL cold_read_cycles: got %0d expected 5", rd); end
    checks++;
    if (ma !== 28'h0) begin errors++; $display("FAIL cold_mem_addr: got %07h expected 0000000", ma); end
    checks++;
    if (INSTRUCTION !== 32'hFFEEDDCC) begin errors++; $display("FAIL cold_instr: got %08h expected FFEEDDCC", INSTRUCTION); end
  endtask

  task automatic test_same_block_hits();
    logic [31:0] addrs [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] exp   [3] = '{32'hBBAA9988, 32'h77665544, 32'h33221100};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      ADDRESS = addrs[i];
      #1;
      $display("hit addr=%08h: BUSYWAIT=%b MEM_READ=%b instr=%08h", addrs[i], BUSYWAIT, MEM_READ, INSTRUCTION);
      checks++;
      if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL hit_busywait %0d: got %b expected 0", i, BUSYWAIT); end
      checks++;
      if (MEM_READ !== 1'b0) begin errors++; $display("FAIL hit_mem_read %0d: got %b expected 0", i, MEM_READ); end
      checks++;
      if (INSTRUCTION !== exp[i]) begin errors++; $display("FAIL hit_instr %0d: got %08h expected %08h", i, INSTRUCTION, exp[i]); end
    end
  endtask

  task automatic test_conflict_eviction();
    logic [31:0] addrs [3] = '{32'h0, 32'h80, 32'h0};
    logic [27:0] exp_ma [3] = '{28'h0, 28'h8, 28'h0};
    logic [31:0] exp_in [3] = '{32'hFFEEDDCC, 32'h00000228, 32'hFFEEDDCC};
    int busy, rd;
    logic [27:0] ma;
    @(negedge CLK);
    RESET = 1'b1;
    ADDRESS = 32'h0;
    mem_k = 2;
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i], busy, rd, ma);
      $display("evict fetch %08h: busy=%0d mem_addr=%07h instr=%08h", addrs[i], busy, ma, INSTRUCTION);
      checks++;
      if (busy != 5) begin errors++; $display("FAIL evict_busy %0d: got %0d expected 5", i, busy); end
      checks++;
      if (ma !== exp_ma[i]) begin errors++; $display("FAIL evict_mem_addr %0d: got %07h expected %07h", i, ma, exp_ma[i]); end
      checks++;
      if (INSTRUCTION !== exp_in[i]) begin errors++; $display("FAIL evict_instr %0d: got %08h expected %08h", i, INSTRUCTION, exp_in[i]); end
    end
  endtask

  task automatic test_reset_mid_refill();
    int busy, rd;
    logic [27:0] ma;
    mem_k = 6;
    @(negedge CLK);
    ADDRESS = 32'h40;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL midrst_miss: got %b expected 1", BUSYWAIT); end
    @(negedge CLK); #1;
    checks++;
    if (MEM_READ !== 1'b1) begin errors++; $display("FAIL midrst_read_start: got %b expected 1", MEM_READ); end
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    $display("reset in refill cycle 3: MEM_READ=%b BUSYWAIT=%b", MEM_READ, BUSYWAIT);
    checks++;
    if (MEM_READ !== 1'b0) begin errors++; $display("FAIL midrst_mem_read: got %b expected 0", MEM_READ); end
    fetch(32'h40, busy, rd, ma);
    $display("refetch 0x40: busy=%0d mem_addr=%07h instr=%08h", busy, ma, INSTRUCTION);
    checks++;
    if (busy != 9) begin errors++; $display("FAIL midrst_refetch_busy: got %0d expected 9", busy); end
    checks++;
    if (INSTRUCTION !== 32'h00000128) begin errors++; $display("FAIL midrst_instr: got %08h expected 00000128", INSTRUCTION); end
  endtask

  task automatic test_address_wiggle();
    int rd = 0;
    int busy;
    logic [27:0] ma;
    mem_k = 3;
    @(negedge CLK);
    ADDRESS = 32'h100;
    #1;
    @(negedge CLK);
    ADDRESS = 32'h200;
    #1;
    while (MEM_READ === 1'b1 && rd < 100) begin
      rd++;
      checks++;
      if (MEM_ADDRESS !== 28'h0000010) begin errors++; $display("FAIL wiggle_mem_addr: got %07h expected 0000010", MEM_ADDRESS); end
      @(negedge CLK); #1;
    end
    checks++;
    if (rd != 4) begin errors++; $display("FAIL wiggle_read_cycles: got %0d expected 4", rd); end
    ADDRESS = 32'h100;
    @(negedge CLK); #1;
    $display("wiggle back to 0x100: BUSYWAIT=%b instr=%08h", BUSYWAIT, INSTRUCTION);
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL wiggle_hit: got %b expected 0", BUSYWAIT); end
    checks++;
    if (INSTRUCTION !== 32'h00000428) begin errors++; $display("FAIL wiggle_instr: got %08h expected 00000428", INSTRUCTION); end
    fetch(32'h40, busy, rd, ma);
    checks++;
    if (busy != 0) begin errors++; $display("FAIL wiggle_line4_kept: got busy %0d expected 0", busy); end
    fetch(32'h200, busy, rd, ma);
    $display("fetch 0x200: busy=%0d mem_addr=%07h instr=%08h", busy, ma, INSTRUCTION);
    checks++;
    if (busy != 6) begin errors++; $display("FAIL wiggle_0x200_miss: got busy %0d expected 6", busy); end
    checks++;
    if (ma !== 28'h0000020) begin errors++; $display("FAIL wiggle_0x200_addr: got %07h expected 0000020", ma); end
  endtask

  task automatic test_zero_wait();
    int busy, rd;
    logic [27:0] ma;
    mem_k = 0;
    fetch(32'h20, busy, rd, ma);
    $display("zero-wait 0x20: busy=%0d rd=%0d mem_addr=%07h instr=%08h", busy, rd, ma, INSTRUCTION);
    checks++;
    if (rd != 1) begin errors++; $display("FAIL zw_read_cycles: got %0d expected 1", rd); end
    checks++;
    if (busy != 3) begin errors++; $display("FAIL zw_busy_cycles: got %0d expected 3", busy); end
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL zw_hit: got %b expected 0", BUSYWAIT); end
    checks++;
    if (INSTRUCTION !== 32'h000000A8) begin errors++; $display("FAIL zw_instr: got %08h expected 000000A8", INSTRUCTION); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_block_hits();
    test_conflict_eviction();
    test_reset_mid_refill();
    test_address_wiggle();
    test_zero_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
